avalon_mem_responder: RTL and testbench
=======================================

AVALON_MEM_RESPONDER -- requirements
Module: avalon_mem_responder

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2: cycles from read acceptance to readdatavalid; legal range 1..8.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0: forced waitrequest cycles after each accepted command; legal range 0..15.
REQ-003 SHALL have parameter MAX_PENDING, default 4: read-in-flight limit; legal range 1..8.
REQ-004 SHALL have one clock and an asynchronous active-low reset, ports as listed below.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 avs_s0_address  in  32  byte address; word index = address[8:5]; address[4:0] ignored.
REQ-008 avs_s0_read  in  1  read command.
REQ-009 avs_s0_write  in  1  write command.
REQ-010 avs_s0_writedata  in  256  write data.
REQ-011 avs_s0_waitrequest  out  1  high = command not accepted this cycle.
REQ-012 avs_s0_readdata  out  256  read data, valid only with readdatavalid.
REQ-013 avs_s0_readdatavalid  out  1  one-cycle pulse per accepted read.
REQ-014 err  out  1  sticky protocol/range error flag.

Function
REQ-015 Storage SHALL be a 16 x 256-bit word array, byte range 0..511.
REQ-016 A command SHALL be accepted on a rising edge where read or write is high and waitrequest is low.
REQ-017 FSM SHALL have states READY and STALL.
REQ-018 READY: waitrequest low, except when pending reads = MAX_PENDING and read is high (then waitrequest high).
REQ-019 READY to STALL on acceptance when WAIT_CYCLES > 0; stall counter loads WAIT_CYCLES.
REQ-020 STALL: waitrequest high; counter decrements each cycle; return to READY when counter reaches 0.
REQ-021 Accepted write SHALL update the addressed word at the acceptance edge.
REQ-022 Accepted read SHALL sample the addressed word at the acceptance edge; a later write to that word does not alter it.
REQ-023 readdatavalid SHALL rise exactly READ_LATENCY cycles after the acceptance edge.
REQ-024 Read responses SHALL be returned in acceptance order, back-to-back reads giving back-to-back pulses.
REQ-025 Pending count SHALL increment on read accept, decrement on readdatavalid, and be unchanged when both occur in one cycle.
REQ-026 read and write high together SHALL execute the write, drop the read, and set err.
REQ-027 Address >= 512: write dropped; read returns all-zero data with normal latency; err set.
REQ-028 err SHALL clear only on reset.
REQ-029 readdata SHALL hold its last value when readdatavalid is low.
REQ-030 Commands are not accepted while waitrequest is high; the master SHALL hold them, and the block keeps no record of refused cycles.

Reset
REQ-031 On reset_n low: state READY, waitrequest 0, readdatavalid 0, readdata 0, err 0, pending 0, stall counter 0, memory cleared to zero.
REQ-032 Reset asserted mid-operation SHALL discard in-flight reads; no readdatavalid pulse follows deassertion.
REQ-033 Reset deassertion SHALL take effect on the first clk edge after release, with no accept on that edge.

Structure
REQ-034 Shared package avalon_pkg SHALL hold DATA_W=256, ADDR_W=32, MEM_WORDS=16, and the state enum {READY, STALL}.
REQ-035 The read latency pipe (valid plus 256-bit data shift stages, READ_LATENCY deep) SHALL be a sub-module avalon_rd_pipe; everything else stays in the top.

Verification
REQ-036 Write 0xA5..A5 @0, then read @0 (WAIT_CYCLES=0, READ_LATENCY=2) -> readdatavalid 2 cycles after accept, readdata 0xA5..A5, err 0.
REQ-037 Write words i=0..9 @32*i with data i, then read 10 back-to-back -> 10 consecutive valid pulses carrying 0..9 in order.
REQ-038 WAIT_CYCLES=3: issue 2 writes back-to-back -> waitrequest high exactly 3 cycles between the accepts.
REQ-039 MAX_PENDING=1, READ_LATENCY=4: 2 back-to-back reads -> second read stalled until the first valid pulse, then accepted.
REQ-040 read+write together @64 with data 0x1 -> word 2 = 0x1, no valid pulse, err 1; read @512 -> zero data, err stays 1.
REQ-041 Reset asserted one cycle after a read accept -> no readdatavalid after release; all outputs 0; read @0 returns 0.

Source files
------------

// File: rtl/avalon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avalon_pkg
// Description : Shared widths, memory geometry, FSM state type and address
//               range helper for the Avalon-MM memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package avalon_pkg;

    localparam int DATA_W    = 256;
    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 16;

    // Word index width and byte-offset width inside one 256-bit word
    localparam int IDX_W     = $clog2(MEM_WORDS);
    localparam int OFS_W     = $clog2(DATA_W / 8);
    localparam int MEM_BYTES = MEM_WORDS * (DATA_W / 8);

    typedef enum logic [0:0] {
        READY = 1'b0,
        STALL = 1'b1
    } state_t;

    // True when the byte address falls inside the backing store
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(MEM_BYTES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : avalon_rd_pipe
// Description : Fixed-latency read response pipe. Stage 0 captures the word
//               at the acceptance edge; each later stage only loads when the
//               stage before it is valid, so the output data holds between
//               responses.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_rd_pipe
    import avalon_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [LATENCY-1:0] r_valid;
    logic [DATA_W-1:0]  r_data [LATENCY];

    // Shift valid every cycle; move data only alongside a valid token
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= in_valid;
            if (in_valid) begin
                r_data[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign out_valid = r_valid[LATENCY-1];
    assign out_data  = r_data[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/avalon_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : avalon_mem_responder
// Description : Avalon-MM slave backed by a 16 x 256-bit memory. Supports
//               forced wait cycles after each command, a fixed read latency
//               and a limit on reads in flight. Protocol and range errors
//               raise a sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_mem_responder
    import avalon_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int WAIT_CYCLES  = 0,
    parameter int MAX_PENDING  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_s0_address,
    input  logic              avs_s0_read,
    input  logic              avs_s0_write,
    input  logic [DATA_W-1:0] avs_s0_writedata,
    output logic              avs_s0_waitrequest,
    output logic [DATA_W-1:0] avs_s0_readdata,
    output logic              avs_s0_readdatavalid,
    output logic              err
);

    localparam int                    c_pend_w   = $clog2(MAX_PENDING + 1);
    localparam logic [c_pend_w-1:0]   c_max_pend = c_pend_w'(MAX_PENDING);
    localparam logic [c_pend_w-1:0]   c_pend_one = c_pend_w'(1);
    localparam logic [3:0]            c_wait     = 4'(WAIT_CYCLES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_stall_cnt;
    logic [c_pend_w-1:0] r_pending;
    logic                r_active;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [MEM_WORDS];

    logic                w_busy;
    logic                w_accept;
    logic                w_acc_rd;
    logic                w_acc_wr;
    logic                w_collide;
    logic                w_in_range;
    logic [IDX_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_rsp_valid;

    assign w_in_range = addr_in_range(avs_s0_address);
    assign w_idx      = avs_s0_address[OFS_W +: IDX_W];
    assign w_collide  = avs_s0_read & avs_s0_write;
    assign w_accept   = (avs_s0_read | avs_s0_write) & ~avs_s0_waitrequest;
    assign w_acc_wr   = w_accept & avs_s0_write;
    // A simultaneous write wins; the read half of a collision is dropped
    assign w_acc_rd   = w_accept & avs_s0_read & ~avs_s0_write;
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: stall after each accepted command when wait cycles are set
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            READY:   if (w_accept && (c_wait != 4'd0)) w_state_nxt = STALL;
            STALL:   if (r_stall_cnt <= 4'd1)          w_state_nxt = READY;
            default: w_state_nxt = READY;
        endcase
    end

    // Output decode: stalled, or a read would exceed the in-flight limit
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            READY:   w_busy = avs_s0_read && (r_pending == c_max_pend);
            STALL:   w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    // The first edge after reset release must never accept a command, so
    // waitrequest is held high until that edge has passed (but low in reset)
    assign avs_s0_waitrequest = reset_n & (~r_active | w_busy);

    // Marks that at least one edge has passed since reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // Stall counter: loaded on acceptance, counts down while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (r_state == READY) begin
            if (w_accept) begin
                r_stall_cnt <= c_wait;
            end
        end else if (r_stall_cnt != 4'd0) begin
            r_stall_cnt <= r_stall_cnt - 4'd1;
        end
    end

    // Reads in flight: up on accept, down on response, hold when both
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else if (w_acc_rd && !w_rsp_valid) begin
            r_pending <= r_pending + c_pend_one;
        end else if (!w_acc_rd && w_rsp_valid) begin
            r_pending <= r_pending - c_pend_one;
        end
    end

    // Backing store; out-of-range writes are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_acc_wr && w_in_range) begin
            r_mem[w_idx] <= avs_s0_writedata;
        end
    end

    // Sticky error on read/write collision or out-of-range access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_accept && (w_collide || !w_in_range)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    avalon_rd_pipe #(
        .LATENCY   (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (w_acc_rd),
        .in_data   (w_rd_word),
        .out_valid (w_rsp_valid),
        .out_data  (avs_s0_readdata)
    );

    assign avs_s0_readdatavalid = w_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_avalon_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_mem_responder
// Description : Self-checking bench for avalon_mem_responder. Three instances
//               cover the default setup, forced wait cycles, and a single
//               in-flight read with longer latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_mem_responder;
    import avalon_pkg::*;

    typedef struct { int d; int c; logic [DATA_W-1:0] data; } resp_t;
    typedef struct { int d; int a; } racc_t;

    logic                   clk     = 1'b0;
    logic                   reset_n = 1'b0;
    logic [2:0][ADDR_W-1:0] addr    = '0;
    logic [2:0]             rd      = '0;
    logic [2:0]             wr      = '0;
    logic [2:0][DATA_W-1:0] wdata   = '0;
    wire  [2:0]             wreq;
    wire  [2:0]             rvalid;
    wire  [2:0]             errf;
    wire  [2:0][DATA_W-1:0] rdata;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Reference state: memory image, sticky error, last accept cycle,
    // expected and observed responses, accepted-read log
    logic [DATA_W-1:0] mmem [3][MEM_WORDS];
    bit                merr [3];
    int                last_acc [3];
    resp_t             expq[$];
    resp_t             obs[$];
    racc_t             raccq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++)
            if (rvalid[k] === 1'b1) obs.push_back('{k, cyc, rdata[k]});
    end

    avalon_mem_responder #(.READ_LATENCY(2), .WAIT_CYCLES(0), .MAX_PENDING(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .avs_s0_address(addr[0]), .avs_s0_read(rd[0]),
        .avs_s0_write(wr[0]), .avs_s0_writedata(wdata[0]), .avs_s0_waitrequest(wreq[0]),
        .avs_s0_readdata(rdata[0]), .avs_s0_readdatavalid(rvalid[0]), .err(errf[0]));

    avalon_mem_responder #(.READ_LATENCY(2), .WAIT_CYCLES(3), .MAX_PENDING(4)) u_dut_wait (
        .clk(clk), .reset_n(reset_n), .avs_s0_address(addr[1]), .avs_s0_read(rd[1]),
        .avs_s0_write(wr[1]), .avs_s0_writedata(wdata[1]), .avs_s0_waitrequest(wreq[1]),
        .avs_s0_readdata(rdata[1]), .avs_s0_readdatavalid(rvalid[1]), .err(errf[1]));

    avalon_mem_responder #(.READ_LATENCY(4), .WAIT_CYCLES(0), .MAX_PENDING(1)) u_dut_pend (
        .clk(clk), .reset_n(reset_n), .avs_s0_address(addr[2]), .avs_s0_read(rd[2]),
        .avs_s0_write(wr[2]), .avs_s0_writedata(wdata[2]), .avs_s0_waitrequest(wreq[2]),
        .avs_s0_readdata(rdata[2]), .avs_s0_readdatavalid(rvalid[2]), .err(errf[2]));

    function automatic int lat_of(input int d);  return (d == 2) ? 4 : 2; endfunction
    function automatic int wait_of(input int d); return (d == 1) ? 3 : 0; endfunction
    function automatic int maxp_of(input int d); return (d == 2) ? 1 : 4; endfunction

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Cycle c is the interval after edge c. A read accepted at edge a keeps
    // its slot from cycle a through cycle a+L-1, the cycle it is delivered.
    // After any accept at edge a, cycles a .. a+W-1 are forced stalls.
    function automatic bit exp_busy(input int d, input bit r, input int c);
        int pend;
        pend = 0;
        foreach (raccq[i])
            if (raccq[i].d == d && raccq[i].a <= c && raccq[i].a + lat_of(d) - 1 >= c)
                pend++;
        if (c - last_acc[d] < wait_of(d)) return 1'b1;
        return r && (pend >= maxp_of(d));
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] o, input logic [DATA_W-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            merr[k] = 1'b0;
            last_acc[k] = -1000;
            for (int w = 0; w < MEM_WORDS; w++) mmem[k][w] = '0;
        end
        expq.delete();
        raccq.delete();
    endtask

    // Present one command from a negedge, hold it until accepted, update model
    task automatic do_cmd(input int d, input bit r, input bit w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] dat, output int acc_c, output int refused);
        bit                done;
        bit                busy_exp;
        logic [DATA_W-1:0] rdv;
        done = 1'b0;
        refused = 0;
        acc_c = -1;
        rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = dat;
        while (!done && refused <= 40) begin
            #1;
            busy_exp = exp_busy(d, r, cyc);
            chk("waitrequest", wreq[d], busy_exp);
            done = (wreq[d] === 1'b0);
            @(negedge clk);
            if (!done) refused++;
        end
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        chk("accept_within_bound", done, 1'b1);
        if (!done) return;
        acc_c = cyc;
        last_acc[d] = acc_c;
        if (r && !w) begin
            rdv = (a < 32'd512) ? mmem[d][a[8:5]] : '0;
            expq.push_back('{d, acc_c + lat_of(d) - 1, rdv});
            raccq.push_back('{d, acc_c});
        end
        if (w && a < 32'd512) mmem[d][a[8:5]] = dat;
        if ((r && w) || a >= 32'd512) merr[d] = 1'b1;
    endtask

    task automatic drain_check(input string tag);
        idle(12);
        chk({tag, ":resp_count"}, obs.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            chk({tag, ":resp_dut"},   obs[i].d,    expq[i].d);
            chk({tag, ":resp_cycle"}, obs[i].c,    expq[i].c);
            chk({tag, ":resp_data"},  obs[i].data, expq[i].data);
        end
        if (expq.size() > 0) chk({tag, ":rdata_hold"}, rdata[expq[$].d], expq[$].data);
        for (int k = 0; k < 3; k++) chk({tag, ":err"}, errf[k], merr[k]);
        obs.delete();
        expq.delete();
        raccq.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, ":waitrequest"},   wreq[k],   '0);
            chk({tag, ":readdatavalid"}, rvalid[k], '0);
            chk({tag, ":readdata"},      rdata[k],  '0);
            chk({tag, ":err"},           errf[k],   '0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int                ac, rf, a1, a2, r1, r2, op;
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] pat;

        model_clear();
        reset_n = 1'b0;
        idle(3);
        check_zero_outputs("reset");

        // Release with a write already presented: the first edge must not take it
        addr[0] = '0; wdata[0] = {32{8'h3C}}; wr[0] = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        wr[0] = 1'b0;
        idle(1);
        do_cmd(0, 1'b1, 1'b0, 32'd0, '0, ac, rf);
        drain_check("first_edge");

        // Single write then read of the A5 pattern
        pat = {32{8'hA5}};
        do_cmd(0, 1'b0, 1'b1, 32'd0, pat, ac, rf);
        do_cmd(0, 1'b1, 1'b0, 32'd0, '0, ac, rf);
        drain_check("a5_word");

        // Ten words then ten back-to-back reads
        for (int i = 0; i < 10; i++) do_cmd(0, 1'b0, 1'b1, ADDR_W'(32 * i), DATA_W'(i), ac, rf);
        for (int i = 0; i < 10; i++) begin
            do_cmd(0, 1'b1, 1'b0, ADDR_W'(32 * i), '0, ac, rf);
            chk("b2b_refused", rf, 0);
        end
        drain_check("b2b_reads");

        // Random in-range traffic with ignored low address bits
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 2);
            ra = {23'd0, 4'($urandom_range(0, 15)), 5'($urandom)};
            if (op == 0)      do_cmd(0, 1'b0, 1'b1, ra, rand_word(), ac, rf);
            else if (op == 1) do_cmd(0, 1'b1, 1'b0, ra, '0, ac, rf);
            else              idle($urandom_range(1, 2));
        end
        drain_check("rand_inrange");

        // Collision, then out-of-range read
        do_cmd(0, 1'b1, 1'b1, 32'd64, DATA_W'(1), ac, rf);
        drain_check("collide");
        chk("collide_err", errf[0], 1'b1);
        do_cmd(0, 1'b1, 1'b0, 32'd512, '0, ac, rf);
        do_cmd(0, 1'b1, 1'b0, 32'd64, '0, ac, rf);
        drain_check("range_read");
        chk("range_err_sticky", errf[0], 1'b1);

        // Random traffic including collisions and out-of-range addresses
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 3);
            ra = ($urandom_range(0, 3) == 0) ? (32'd512 + 32'($urandom_range(0, 4000)))
                                             : {23'd0, 4'($urandom_range(0, 15)), 5'($urandom)};
            if (op == 0)      do_cmd(0, 1'b0, 1'b1, ra, rand_word(), ac, rf);
            else if (op == 1) do_cmd(0, 1'b1, 1'b0, ra, '0, ac, rf);
            else if (op == 2) do_cmd(0, 1'b1, 1'b1, ra, rand_word(), ac, rf);
            else              idle(1);
        end
        drain_check("rand_full");

        // Forced wait cycles: three stall cycles between two write accepts
        do_cmd(1, 1'b0, 1'b1, 32'd0, rand_word(), a1, r1);
        do_cmd(1, 1'b0, 1'b1, 32'd32, rand_word(), a2, r2);
        chk("wait_first_refused", r1, 0);
        chk("wait_stall_cycles", r2, 3);
        chk("wait_accept_gap", a2 - a1, 4);
        do_cmd(1, 1'b1, 1'b0, 32'd0, '0, ac, rf);
        do_cmd(1, 1'b1, 1'b0, 32'd32, '0, ac, rf);
        drain_check("wait_cycles");

        // Single in-flight read: second read waits for the first response
        do_cmd(2, 1'b0, 1'b1, 32'd0, rand_word(), ac, rf);
        do_cmd(2, 1'b0, 1'b1, 32'd32, rand_word(), ac, rf);
        do_cmd(2, 1'b1, 1'b0, 32'd0, '0, a1, r1);
        do_cmd(2, 1'b1, 1'b0, 32'd32, '0, a2, r2);
        chk("pend_refused", r2, 4);
        idle(8);
        chk("pend_pulses", obs.size(), 2);
        if (obs.size() > 0) chk("pend_accept_after_pulse", (a2 > obs[0].c), 1'b1);
        drain_check("pend_limit");

        // Reset the cycle after a read accept: the read must vanish
        do_cmd(0, 1'b0, 1'b1, 32'd0, rand_word(), ac, rf);
        do_cmd(0, 1'b1, 1'b0, 32'd0, '0, ac, rf);
        #2 reset_n = 1'b0;
        model_clear();
        idle(2);
        check_zero_outputs("mid_reset");
        reset_n = 1'b1;
        idle(10);
        chk("no_pulse_after_reset", obs.size(), 0);
        check_zero_outputs("post_reset");
        do_cmd(0, 1'b1, 1'b0, 32'd0, '0, ac, rf);
        drain_check("read_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
